// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] NOP_WORD = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_rsp_t;

endpackage

// File: rtl/if_hold_buf.sv
// Holds the {PC, Instruction} pair captured while ID freezes the pipeline.
module if_hold_buf
    import if_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       clear,
    input  fetch_rsp_t din,
    output fetch_rsp_t dout
);

    always_ff @(posedge clk) begin
        if (rst || clear)
            dout <= '0;
        else if (load)
            dout <= din;
    end

endmodule

// File: rtl/if_stage_fetch.sv
// IF stage fetch controller with wait-state, freeze-hold and branch-drain handling.
// Optional IF_PERF_CNT_EN adds stall_cycles/redirects performance counters.
module if_stage_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        Branch_taken,
    input  logic [31:0] BranchAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        fetch_stall
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] redirects
`endif
);

    if_state_e   state, state_nxt;
    logic [31:0] pc_reg, pc_nxt;
    logic [31:0] redirect, redirect_nxt;
    logic [31:0] pc_inc;
    logic        hold_load, hold_clear;
    fetch_rsp_t  rsp, hold_q;

    assign pc_inc    = pc_reg + PC_INC;
    assign imem_addr = pc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc_reg   <= RESET_PC;
            redirect <= '0;
        end else begin
            state    <= state_nxt;
            pc_reg   <= pc_nxt;
            redirect <= redirect_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_reg;
        redirect_nxt = redirect;
        imem_req     = 1'b1;
        fetch_stall  = 1'b1;
        rsp          = '{pc: '0, instr: NOP_WORD};
        hold_load    = 1'b0;
        hold_clear   = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (Branch_taken) begin
                        pc_nxt = BranchAddr;
                    end else begin
                        fetch_stall = 1'b0;
                        rsp         = '{pc: pc_inc, instr: imem_rdata};
                        if (freeze) begin
                            hold_load = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            pc_nxt = pc_inc;
                        end
                    end
                end else if (Branch_taken) begin
                    redirect_nxt = BranchAddr;
                    state_nxt    = DRAIN;
                end
            end
            DRAIN: begin
                // The outstanding word is dropped; a branch in this very cycle is the latest target.
                if (Branch_taken)
                    redirect_nxt = BranchAddr;
                if (imem_ready) begin
                    pc_nxt    = Branch_taken ? BranchAddr : redirect;
                    state_nxt = FETCH;
                end
            end
            HOLD: begin
                imem_req    = 1'b0;
                fetch_stall = 1'b0;
                rsp         = hold_q;
                if (Branch_taken) begin
                    pc_nxt     = BranchAddr;
                    hold_clear = 1'b1;
                    state_nxt  = FETCH;
                end else if (!freeze) begin
                    pc_nxt     = pc_inc;
                    hold_clear = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign PC          = rsp.pc;
    assign Instruction = rsp.instr;

    if_hold_buf u_hold_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (hold_load),
        .clear (hold_clear),
        .din   (rsp),
        .dout  (hold_q)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            redirects    <= '0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, fetch_stall};
            redirects    <= redirects + {31'd0, Branch_taken};
        end
    end
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch: stimulus pushes expected deliveries, a monitor pops and compares.
module tb_if_stage_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        Branch_taken = 1'b0;
    logic [31:0] BranchAddr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b1;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        fetch_stall;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] redirects;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    if_stage_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .Branch_taken (Branch_taken),
        .BranchAddr   (BranchAddr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .PC           (PC),
        .Instruction  (Instruction),
        .fetch_stall  (fetch_stall)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .redirects    (redirects)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every valid delivery from a live request must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && imem_req === 1'b1 && fetch_stall === 1'b0) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_delivery: got PC %h want none", PC);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_pc", PC, e.pc);
                chk("sb_instr", Instruction, e.ins);
            end
        end
    end

    task automatic drive(input logic r, input logic f, input logic b,
                         input logic [31:0] ba, input logic rdy);
        rst = r; freeze = f; Branch_taken = b; BranchAddr = ba; imem_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] a);
        exp_t e;
        e.pc  = pc;
        e.ins = mem_word(a);
        q.push_back(e);
    endtask

    task automatic cyc_fetch(input logic [31:0] a);
        logic [31:0] nxt;
        nxt = a + 32'd4;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        push(nxt, a);
        @(negedge clk);
        chk("fetch_addr", imem_addr, a);
        chk("fetch_stall_low", {31'd0, fetch_stall}, 32'd0);
        tick();
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        tick();
        tick();

        // Zero-wait streaming from reset
        for (int i = 0; i < 4; i++) cyc_fetch(32'(i * 4));

        // Two wait states at 0x10
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
            @(negedge clk);
            chk("wait_addr", imem_addr, 32'h10);
            chk("wait_stall", {31'd0, fetch_stall}, 32'd1);
            chk("wait_pc_zero", PC, 32'd0);
            chk("wait_instr_zero", Instruction, 32'd0);
            tick();
        end
        for (int a = 'h10; a < 'h20; a += 4) cyc_fetch(32'(a));

        // Freeze three cycles at 0x20
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
        push(32'h24, 32'h20);
        @(negedge clk);
        chk("frz_addr", imem_addr, 32'h20);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, (i < 2) ? 1'b1 : 1'b0, 1'b0, '0, 1'b1);
            @(negedge clk);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_pc", PC, 32'h24);
            chk("hold_instr", Instruction, mem_word(32'h20));
            chk("hold_stall", {31'd0, fetch_stall}, 32'd0);
            tick();
        end
        for (int a = 'h24; a < 'h40; a += 4) cyc_fetch(32'(a));

        // Branch to 0x100 during a wait at 0x40
        drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        @(negedge clk);
        chk("br_wait_stall", {31'd0, fetch_stall}, 32'd1);
        chk("br_wait_pc", PC, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("drain_addr", imem_addr, 32'h40);
        chk("drain_stall", {31'd0, fetch_stall}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("drain_done_stall", {31'd0, fetch_stall}, 32'd1);
        chk("drain_done_instr", Instruction, 32'd0);
        tick();
        cyc_fetch(32'h100);

        // Last redirect target wins while draining
        drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
        @(negedge clk);
        chk("drain2_addr", imem_addr, 32'h104);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("drain2_stall", {31'd0, fetch_stall}, 32'd1);
        tick();
        cyc_fetch(32'h300);

        // Branch out of HOLD while still frozen
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
        push(32'h308, 32'h304);
        @(negedge clk);
        chk("frz2_addr", imem_addr, 32'h304);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h80, 1'b1);
        @(negedge clk);
        chk("hold_br_req", {31'd0, imem_req}, 32'd0);
        chk("hold_br_pc", PC, 32'h308);
        tick();
        cyc_fetch(32'h80);

        // Address wrap at the top of the space
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        @(negedge clk);
        chk("br_ready_stall", {31'd0, fetch_stall}, 32'd1);
        chk("br_ready_pc", PC, 32'd0);
        tick();
        cyc_fetch(32'hFFFF_FFFC);
        cyc_fetch(32'h0);

        // Reset during a wait at 0x30
        drive(1'b0, 1'b0, 1'b1, 32'h30, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("rst_wait_addr", imem_addr, 32'h30);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h500, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        push(32'h4, 32'h0);
        @(negedge clk);
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
`ifdef IF_PERF_CNT_EN
        chk("post_rst_stall_cnt", stall_cycles, 32'd0);
        chk("post_rst_redir_cnt", redirects, 32'd0);
`endif
        tick();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage_fetch.md
IF_STAGE_FETCH -- requirements
Module: if_stage_fetch

Interface
- REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the fetch address after reset.
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 rst  input  1  reset, synchronous, active-high.
- REQ-004 freeze  input  1  hazard stall from ID; 1 holds the current fetch result.
- REQ-005 Branch_taken  input  1  redirect request from EXE.
- REQ-006 BranchAddr  input  32  redirect target, byte address, word aligned.
- REQ-007 imem_req  output  1  instruction memory request, held until imem_ready.
- REQ-008 imem_addr  output  32  request address, valid while imem_req=1.
- REQ-009 imem_rdata  input  32  instruction word, valid when imem_ready=1.
- REQ-010 imem_ready  input  1  read completion; may assert in the same cycle as imem_req.
- REQ-011 PC  output  32  fetched address + 4, feeds the IF pipeline register.
- REQ-012 Instruction  output  32  fetched word, feeds the IF pipeline register.
- REQ-013 fetch_stall  output  1  1 when PC/Instruction are not valid; ORed into the IF register freeze at top level.

Function
- REQ-014 States: FETCH, HOLD, DRAIN; pc_reg holds the current fetch address.
- REQ-015 FETCH: imem_req=1, imem_addr=pc_reg, fetch_stall=~imem_ready.
- REQ-016 FETCH with imem_ready=1, Branch_taken=0, freeze=0: PC=pc_reg+4, Instruction=imem_rdata, pc_reg<=pc_reg+4, stay FETCH.
- REQ-017 FETCH with imem_ready=1, Branch_taken=0, freeze=1: capture imem_rdata and pc_reg+4 into the hold buffer, go HOLD.
- REQ-018 FETCH with imem_ready=1, Branch_taken=1: discard the word, fetch_stall=1, pc_reg<=BranchAddr, stay FETCH.
- REQ-019 FETCH with imem_ready=0, Branch_taken=1: latch BranchAddr into redirect register, go DRAIN.
- REQ-020 DRAIN: imem_req=1, imem_addr=pc_reg, fetch_stall=1; on imem_ready discard the word, pc_reg<=redirect, go FETCH.
- REQ-021 DRAIN with a further Branch_taken=1: overwrite the redirect register; the last target wins.
- REQ-022 HOLD: imem_req=0, PC and Instruction taken from the hold buffer, fetch_stall=0.
- REQ-023 HOLD with freeze=0, Branch_taken=0: pc_reg<=pc_reg+4, go FETCH.
- REQ-024 HOLD with Branch_taken=1: pc_reg<=BranchAddr, go FETCH; Branch_taken overrides freeze.
- REQ-025 Address arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- REQ-026 When fetch_stall=1, PC and Instruction are 0.
- REQ-027 imem_addr never changes while imem_req=1 and imem_ready=0.

Reset
- REQ-028 rst=1 at a clock edge sets pc_reg=RESET_PC, state=FETCH, hold buffer=0 and redirect register=0.
- REQ-029 Reset during an outstanding request abandons that request; the memory is required to accept a fresh request in the cycle after reset.
- REQ-030 rst has priority over Branch_taken, freeze and imem_ready.

Configuration
- REQ-031 Macro IF_PERF_CNT_EN defined: adds output stall_cycles[31:0], which counts cycles with fetch_stall=1, and output redirects[31:0], which counts accepted Branch_taken events.
- REQ-032 Both counters are cleared by rst, wrap modulo 2^32, and the ports are absent when the macro is undefined.

Structure
- REQ-033 Shared package if_pkg holds the state enum (FETCH/HOLD/DRAIN), PC_INC=4 and the NOP word constant 32'h0.
- REQ-034 Sub-module if_hold_buf holds the captured {PC, Instruction} pair with load and clear controls.

Verification
- REQ-035 Zero-wait memory with imem_ready tied to 1 and no branches, after reset -> imem_addr is 0,4,8,...; PC is 4,8,12,...; fetch_stall=0 every cycle.
- REQ-036 Memory with 2 wait states at addr 0x10 -> fetch_stall=1 for 2 cycles, imem_addr stable at 0x10, then PC=0x14 with the correct word.
- REQ-037 freeze=1 for 3 cycles after fetching 0x20 -> state HOLD, imem_req=0, PC=0x24 held; fetch resumes at 0x24 after release.
- REQ-038 Branch_taken=1 to 0x100 during a wait state at 0x40 -> state DRAIN, the 0x40 word is discarded, next imem_addr=0x100, PC=0x104.
- REQ-039 Branch_taken=1 to 0x80 while in HOLD with freeze=1 -> next imem_addr=0x80 and the hold buffer is discarded.
- REQ-040 rst asserted mid-wait at addr 0x30 -> the next cycle has imem_addr=RESET_PC; with IF_PERF_CNT_EN defined, both counters read 0.
